// File: rtl/uart_rx.sv
// 8N1 serial receiver: 16x oversampled deframer with an internal baud tick.
// Each good byte is presented with a one-cycle o_rx_done strobe; bad stop bits raise o_frame_err instead.
module uart_rx #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 163,
    parameter int DIV_W    = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_rx_data,
    output logic            o_rx_done,
    output logic            o_frame_err
);

    localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int SW    = $clog2(S_MAX);
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [DBIT-1:0]   data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        sync_q, sync_d;
    logic              rx_s;
    logic              tick;

    // Two-flop synchronizer; every decision below looks only at rx_s.
    assign sync_d = {sync_q[0], i_rx};
    assign rx_s   = sync_q[1];

    // Free-running oversample tick, independent of the FSM.
    assign tick  = (div_q == DIV_W'(BAUD_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == SW'(7)) begin
                        // Mid start bit: line back high means it was a glitch.
                        state_d = rx_s ? IDLE : DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) state_d = STOP;
                        else                      n_d     = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        if (rx_s) begin
                            data_d = b_q;
                            done_d = 1'b1;
                        end else begin
                            err_d  = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            div_q   <= '0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            div_q   <= div_d;
            sync_q  <= sync_d;
        end
    end

    assign o_rx_data   = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes the expected frame outcome,
// an independent monitor pops and compares on every strobe.
module tb_uart_rx;

    localparam int BIT = 64;  // BAUD_DIV=4 -> 16 ticks * 4 clocks

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;

    uart_rx #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(4), .DIV_W(8)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_rx       (rx),
        .o_rx_data  (rx_data),
        .o_rx_done  (rx_done),
        .o_frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         t0;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] last_good = 8'h00;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         strobes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rx_done || frame_err) begin
            strobes++;
            chk("strobes_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
            if (sbq.size() == 0) begin
                chk("unexpected_strobe", {30'd0, rx_done, frame_err}, 32'd0);
            end else begin
                exp_t e;
                int   lat;
                e = sbq.pop_front();
                lat = cyc - e.t0;
                chk("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.err});
                chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                chk("latency_in_window", {31'd0, (lat >= 570 && lat <= 710)}, 32'd1);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, {22'd0, rx_data, rx_done, frame_err}, 32'd0);
    endtask

    // Sends one frame. A bad stop bit is held low only for its first part so the
    // receiver's post-error glitch check sees a high line and no phantom frame follows.
    task automatic send(input logic [7:0] d, input bit stop_ok, input int abort_bit);
        if (abort_bit < 0) begin
            sbq.push_back('{err: !stop_ok, data: stop_ok ? d : last_good, t0: cyc});
            if (stop_ok) last_good = d;
        end
        rx = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == abort_bit) begin
                wait_cyc(BIT / 2);
                rst_n = 1'b0;
                last_good = 8'h00;
                wait_cyc(5);
                check_outputs_zero("outputs_in_midframe_reset");
                rx = 1'b1;
                rst_n = 1'b1;
                return;
            end
            wait_cyc(BIT);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_cyc(BIT);
        end else begin
            rx = 1'b0;
            wait_cyc(40);
            rx = 1'b1;
            wait_cyc(BIT - 40);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            wait_cyc(1);
            n++;
        end
        chk(name, sbq.size(), 32'd0);
    endtask

    initial begin
        // Reset held with a busy line
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rx = 1'($urandom);
            wait_cyc(1);
            if (i % 5 == 4) check_outputs_zero("outputs_in_reset");
        end
        rx = 1'b1;
        rst_n = 1'b1;
        wait_cyc(1000);
        chk("idle_no_strobe", strobes, 32'd0);
        check_outputs_zero("outputs_after_idle");

        // Single good frame
        send(8'hA5, 1'b1, -1);
        wait_cyc(200);
        drain("drain_a5");
        chk("data_hold_a5", {24'd0, rx_data}, 32'h0000_00A5);

        // Bad stop bit: error strobe, data keeps 0xA5
        send(8'h5A, 1'b0, -1);
        wait_cyc(200);
        drain("drain_framing");
        chk("data_kept_after_err", {24'd0, rx_data}, 32'h0000_00A5);

        // Back-to-back frames, no idle gap
        send(8'h00, 1'b1, -1);
        send(8'hFF, 1'b1, -1);
        wait_cyc(200);
        drain("drain_b2b");
        chk("data_hold_ff", {24'd0, rx_data}, 32'h0000_00FF);

        // Start-bit glitch, then a real frame
        rx = 1'b0;
        wait_cyc(16);
        rx = 1'b1;
        wait_cyc(200);
        send(8'h3C, 1'b1, -1);
        wait_cyc(200);
        drain("drain_glitch");

        // Reset during data bit 4, then the same byte again
        send(8'h81, 1'b1, 4);
        wait_cyc(300);
        check_outputs_zero("outputs_after_abort");
        send(8'h81, 1'b1, -1);
        wait_cyc(200);
        drain("drain_after_abort");
        chk("data_81", {24'd0, rx_data}, 32'h0000_0081);

        // Random frames with random gaps and occasional bad stop bits
        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            bit         ok;
            int         gap;
            d  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send(d, ok, -1);
            if (!ok)                            gap = BIT + int'($urandom_range(0, 40));
            else if ($urandom_range(0, 2) == 0) gap = 0;
            else                                gap = int'($urandom_range(0, 100));
            rx = 1'b1;
            wait_cyc(gap);
        end
        wait_cyc(200);
        drain("drain_random");
        chk("final_data", {24'd0, rx_data}, {24'd0, last_good});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
